// File: rtl/display_scanner.sv
// display_scanner: sweeps the display-slot interface and streams every slot as
// 14 ASCII characters (5-char name, ':', 8 uppercase hex digits) to the LCD writer.
module display_scanner #(
  parameter int NUM_SLOTS      = 44,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        force_refresh,
  output logic [5:0]  display_number,
  input  logic        display_valid,
  input  logic [39:0] display_name,
  input  logic [31:0] display_value,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic [5:0]  char_slot,
  output logic [3:0]  char_col,
  output logic        busy,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [5:0] LAST_SLOT = 6'(NUM_SLOTS);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, LATCH, EMIT, DONE} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic [5:0]       r_slot;
  logic [5:0]       w_slotNext;
  logic [3:0]       r_col;
  logic [3:0]       w_colNext;
  logic             r_valid;
  logic [39:0]      r_name;
  logic [31:0]      r_value;
  logic             w_req;
  logic             w_xfer;
  logic [7:0]       w_nameByte;
  logic [3:0]       w_nibble;
  logic [7:0]       w_char;

  assign w_req  = force_refresh || (r_cnt == CNT_LAST);
  assign w_xfer = (r_state == EMIT) && char_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Requests arriving outside IDLE collapse into one pending frame, which IDLE consumes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (r_state == IDLE) begin
      r_pending <= 1'b0;
    end else if (w_req) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_slot  <= 6'd0;
      r_col   <= 4'd0;
    end else begin
      r_state <= w_stateNext;
      r_slot  <= w_slotNext;
      r_col   <= w_colNext;
    end
  end

  // The provider answers a registered cycle after display_number moves, so LATCH samples two cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_name  <= 40'd0;
      r_value <= 32'd0;
    end else if (r_state == LATCH) begin
      r_valid <= display_valid;
      r_name  <= display_name;
      r_value <= display_value;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_slotNext  = r_slot;
    w_colNext   = r_col;
    case (r_state)
      IDLE: begin
        if (w_req || r_pending) begin
          w_slotNext  = 6'd1;
          w_stateNext = REQ;
        end
      end
      REQ:   w_stateNext = WAIT;
      WAIT:  w_stateNext = LATCH;
      LATCH: begin
        w_colNext   = 4'd0;
        w_stateNext = EMIT;
      end
      EMIT: begin
        if (w_xfer) begin
          if (r_col == 4'd13) begin
            if (r_slot == LAST_SLOT) begin
              w_stateNext = DONE;
            end else begin
              w_slotNext  = r_slot + 6'd1;
              w_stateNext = REQ;
            end
          end else begin
            w_colNext = r_col + 4'd1;
          end
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Column-to-character mapping; an invalid slot is painted as spaces rather than skipped.
  assign w_nameByte = 8'(r_name >> {(4'd4 - r_col), 3'b000});
  assign w_nibble   = 4'(r_value >> {(4'd13 - r_col), 2'b00});

  always_comb begin
    w_char = 8'h20;
    if (r_valid) begin
      if (r_col <= 4'd4) begin
        w_char = (w_nameByte == 8'h00) ? 8'h20 : w_nameByte;
      end else if (r_col == 4'd5) begin
        w_char = 8'h3A;
      end else if (w_nibble < 4'd10) begin
        w_char = 8'h30 + {4'h0, w_nibble};
      end else begin
        w_char = 8'h37 + {4'h0, w_nibble};
      end
    end
  end

  always_comb begin
    busy           = (r_state == REQ) || (r_state == WAIT) || (r_state == LATCH) || (r_state == EMIT);
    display_number = busy ? r_slot : 6'd0;
    char_valid     = (r_state == EMIT);
    char_data      = char_valid ? w_char : 8'h00;
    char_slot      = char_valid ? r_slot : 6'd0;
    char_col       = char_valid ? r_col : 4'd0;
    frame_done     = (r_state == DONE);
  end

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: drives display_scanner with a registered slot provider and a
// random-ready character sink, comparing every transferred character to a string-formatted model.
`timescale 1ns/1ps
module tb_display_scanner;

  localparam int NUM_SLOTS = 44;
  localparam int REFRESH   = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        force_refresh;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_data;
  logic [5:0]  char_slot;
  logic [3:0]  char_col;
  logic        busy;
  logic        frame_done;

  int passCnt;
  int totalCnt;
  int failCnt;
  int doneCnt;

  bit        tblValid[0:63];
  bit [39:0] tblName[0:63];
  bit [31:0] tblValue[0:63];
  bit [17:0] expQ[$];

  display_scanner #(.NUM_SLOTS(NUM_SLOTS), .REFRESH_CYCLES(REFRESH)) dut (
    .clk(clk), .reset(reset), .force_refresh(force_refresh),
    .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .char_slot(char_slot), .char_col(char_col), .busy(busy), .frame_done(frame_done)
  );

  always #50 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Random slot contents; about a quarter of name bytes are NUL so the space substitution is exercised.
  task automatic randomizeTable();
    for (int s = 0; s < 64; s++) begin
      tblValid[s] = ($urandom_range(0, 4) != 0);
      for (int b = 0; b < 5; b++) begin
        tblName[s][8*b +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(33, 126));
      end
      tblValue[s] = $urandom;
    end
  endtask

  // Expected frame: text rendered with $sformatf, independent of any nibble arithmetic.
  task automatic buildFrame();
    bit [7:0] row[14];
    bit [7:0] b;
    string    h;
    for (int s = 1; s <= NUM_SLOTS; s++) begin
      for (int c = 0; c < 14; c++) row[c] = 8'h20;
      if (tblValid[s]) begin
        for (int i = 0; i < 5; i++) begin
          b      = tblName[s][39-8*i -: 8];
          row[i] = (b == 8'h00) ? 8'h20 : b;
        end
        row[5] = 8'h3A;
        h = $sformatf("%08x", tblValue[s]);
        h = h.toupper();
        for (int i = 0; i < 8; i++) row[6+i] = h[i];
      end
      for (int c = 0; c < 14; c++) expQ.push_back({row[c], 6'(s), 4'(c)});
    end
  endtask

  task automatic applyStimulus(input bit ready, input bit frc);
    logic [5:0]  dn;
    logic        cv;
    logic [17:0] held;
    bit          holding;
    bit [17:0]   exp;
    char_ready    = ready;
    force_refresh = frc;
    #1;
    dn      = display_number;
    cv      = char_valid;
    holding = 0;
    held    = '0;
    if (char_valid === 1'b1 && ready) begin
      checkOutput("char_expected", 64'(expQ.size() > 0), 64'(1));
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        checkOutput("char_data_slot_col", 64'({char_data, char_slot, char_col}), 64'(exp));
      end
    end else if (char_valid === 1'b1) begin
      holding = 1;
      held    = {char_data, char_slot, char_col};
    end
    @(posedge clk);
    #1;
    if (cv === 1'b1) begin
      display_valid = 1'($urandom);
      display_name  = 40'({$urandom, $urandom});
      display_value = $urandom;
    end else begin
      display_valid = tblValid[dn];
      display_name  = tblName[dn];
      display_value = tblValue[dn];
    end
    if (frame_done === 1'b1) doneCnt++;
    if (holding) checkOutput("hold_stable", 64'({char_valid, char_data, char_slot, char_col}), 64'({1'b1, held}));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready except a 5-cycle stall at slot 1 col 8.
  task automatic runFrame(input int mode, input bit withForces, input int stopSlot);
    int stallLeft;
    bit rdy;
    stallLeft = 5;
    for (int n = 0; n < 6000; n++) begin
      if (stopSlot != 0 && char_valid === 1'b1 && char_slot == 6'(stopSlot)) return;
      if (frame_done === 1'b1) break;
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
      if (mode == 2 && char_valid === 1'b1 && char_slot == 6'd1 && char_col == 4'd8 && stallLeft > 0) begin
        rdy = 1'b0;
        stallLeft--;
      end
      applyStimulus(rdy, withForces && (n == 100 || n == 250 || n == 400));
    end
    if (stopSlot == 0) checkOutput("frame_done_seen", 64'(frame_done), 64'(1));
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int busyCycles;
    passCnt = 0; totalCnt = 0; failCnt = 0; doneCnt = 0;
    reset = 1'b1; force_refresh = 1'b0; char_ready = 1'b0;
    display_valid = 1'b0; display_name = '0; display_value = '0;
    for (int s = 0; s < 64; s++) begin tblValid[s] = 0; tblName[s] = '0; tblValue[s] = '0; end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_display_number", 64'(display_number), 64'(0));
    checkOutput("rst_char_valid", 64'(char_valid), 64'(0));
    checkOutput("rst_char_fields", 64'({char_data, char_slot, char_col}), 64'(0));
    checkOutput("rst_busy_done", 64'({busy, frame_done}), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Directed frame: "ADD1H" / 0x1234ABCD in slot 1, blank slot 7, NUL-padded slot 2, stall at col 8.
    randomizeTable();
    tblValid[1] = 1; tblName[1] = 40'h4144443148; tblValue[1] = 32'h1234ABCD;
    tblValid[2] = 1; tblName[2] = 40'h4142000000;
    tblValid[7] = 0;
    expQ.delete(); buildFrame(); doneCnt = 0;
    applyStimulus(1, 1);
    checkOutput("req_display_number", 64'({busy, display_number}), 64'({1'b1, 6'd1}));
    applyStimulus(1, 0);
    checkOutput("wait_no_char", 64'(char_valid), 64'(0));
    applyStimulus(1, 0);
    checkOutput("latch_no_char", 64'({char_valid, display_number}), 64'({1'b0, 6'd1}));
    applyStimulus(1, 0);
    checkOutput("emit_first_char", 64'({char_valid, char_slot, char_col}), 64'({1'b1, 6'd1, 4'd0}));
    runFrame(2, 0, 0);
    checkOutput("frame_a_all_sent", 64'(expQ.size()), 64'(0));
    checkOutput("done_busy_low", 64'(busy), 64'(0));
    applyStimulus(1, 0);
    checkOutput("done_single_pulse", 64'({frame_done, display_number}), 64'(0));
    checkOutput("frame_a_done_count", 64'(doneCnt), 64'(1));

    // Random table, random backpressure.
    randomizeTable();
    expQ.delete(); buildFrame(); doneCnt = 0;
    applyStimulus(1, 1);
    runFrame(1, 0, 0);
    checkOutput("frame_b_all_sent", 64'(expQ.size()), 64'(0));
    applyStimulus(1, 0);
    checkOutput("frame_b_done_count", 64'(doneCnt), 64'(1));

    // Several force pulses while busy yield exactly one follow-on frame.
    doReset();
    randomizeTable();
    expQ.delete(); buildFrame(); buildFrame(); doneCnt = 0;
    applyStimulus(1, 1);
    runFrame(0, 1, 0);
    checkOutput("pend_first_frame_left", 64'(expQ.size()), 64'(NUM_SLOTS * 14));
    applyStimulus(1, 0);
    checkOutput("pend_idle_gap", 64'(busy), 64'(0));
    applyStimulus(1, 0);
    checkOutput("pend_restart", 64'({busy, display_number}), 64'({1'b1, 6'd1}));
    runFrame(0, 0, 0);
    checkOutput("pend_second_all_sent", 64'(expQ.size()), 64'(0));
    busyCycles = 0;
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1, 0);
      if (busy !== 1'b0) busyCycles++;
    end
    checkOutput("pend_no_third_frame", 64'(busyCycles), 64'(0));
    checkOutput("pend_done_count", 64'(doneCnt), 64'(2));

    // Asynchronous reset while emitting slot 20, then a clean restart.
    doReset();
    randomizeTable();
    expQ.delete(); buildFrame();
    applyStimulus(1, 1);
    runFrame(1, 0, 20);
    checkOutput("reached_slot20", 64'({char_valid, char_slot}), 64'({1'b1, 6'd20}));
    reset = 1'b1;
    #1;
    checkOutput("async_clear_char", 64'({char_valid, char_data, char_slot, char_col}), 64'(0));
    checkOutput("async_clear_ctrl", 64'({busy, frame_done, display_number}), 64'(0));
    #20;
    reset = 1'b0;
    expQ.delete(); buildFrame(); doneCnt = 0;
    applyStimulus(1, 1);
    checkOutput("restart_slot1", 64'({busy, display_number}), 64'({1'b1, 6'd1}));
    repeat (3) applyStimulus(1, 0);
    checkOutput("restart_col0", 64'({char_valid, char_slot, char_col}), 64'({1'b1, 6'd1, 4'd0}));
    runFrame(0, 0, 0);
    checkOutput("restart_all_sent", 64'(expQ.size()), 64'(0));

    // Automatic refresh: counter reaches REFRESH-1 after REFRESH-1 edges, frame starts on the next.
    doReset();
    randomizeTable();
    expQ.delete(); buildFrame(); doneCnt = 0;
    busyCycles = 0;
    for (int k = 1; k < REFRESH; k++) begin
      applyStimulus(1, 0);
      if (busy !== 1'b0) busyCycles++;
    end
    checkOutput("auto_not_early", 64'(busyCycles), 64'(0));
    applyStimulus(1, 0);
    checkOutput("auto_start", 64'({busy, display_number}), 64'({1'b1, 6'd1}));
    runFrame(0, 0, 0);
    checkOutput("auto_all_sent", 64'(expQ.size()), 64'(0));

    $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
